// File: rtl/bus_arbiter_4.sv
// Round-robin 4-way owner arbiter for the shared internal bus with bounded tenure and a one-cycle turnaround.
// Grant 1 cycle after request, registered bus word 1 cycle after grant; requesters wait by keeping req high.
module bus_arbiter_4 #(
  parameter int WIDTH    = 18,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [1:0]       sel,
  output logic [3:0]       gnt,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_valid,
  output logic             busy
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] bus_out_q, bus_out_d;
  logic             bus_valid_q, bus_valid_d;

  logic [1:0]       win_idx;
  logic [WIDTH-1:0] owner_dat;
  logic             others_req;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    win_idx    = rr_pick(req, ptr_q);
    others_req = |(req & ~(4'b0001 << owner_q));
    case (owner_q)
      2'd0:    owner_dat = in0;
      2'd1:    owner_dat = in1;
      2'd2:    owner_dat = in2;
      default: owner_dat = in3;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    bus_out_d   = bus_out_q;
    bus_valid_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_SWITCH: begin
        if (|req) begin
          state_d    = ST_OWN;
          owner_d    = win_idx;
          ptr_d      = win_idx + 2'd1;
          hold_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (req[owner_q]) begin
          bus_out_d   = owner_dat;
          bus_valid_d = 1'b1;
        end
        if (!req[owner_q]) begin
          state_d = ST_SWITCH;
        end else if (hold_cnt_q == HOLD_LAST && others_req) begin
          state_d = ST_SWITCH;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Grant and busy are registered copies of the next state so they line up with ownership.
    gnt_d  = (state_d == ST_OWN) ? (4'b0001 << owner_d) : 4'b0000;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 2'd0;
      ptr_q       <= 2'd0;
      hold_cnt_q  <= '0;
      gnt_q       <= 4'b0000;
      busy_q      <= 1'b0;
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
    end
  end

  assign sel       = owner_q;
  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed bench for bus_arbiter_4: vector table plus contention, saturation and overlap sequences.
module tb_bus_arbiter_4;

  localparam logic [17:0] D0 = 18'h00011;
  localparam logic [17:0] D1 = 18'h00122;
  localparam logic [17:0] D2 = 18'h2A5A5;
  localparam logic [17:0] D3 = 18'h3C3C3;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [17:0] in0, in1, in2, in3;
  logic [1:0]  sel;
  logic [3:0]  gnt;
  logic [17:0] bus_out;
  logic        bus_valid;
  logic        busy;

  int tests_run;
  int tests_failed;

  bus_arbiter_4 #(.WIDTH(18), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .sel       (sel),
    .gnt       (gnt),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        vld;
    logic        busy;
    logic [17:0] bout;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] g,
                              input logic [1:0] s, input logic v, input logic b,
                              input logic [17:0] o);
    vec_t t;
    t.rst_n = r; t.req = q; t.gnt = g; t.sel = s; t.vld = v; t.busy = b; t.bout = o;
    return t;
  endfunction

  function automatic logic [17:0] fdat(input int i, input int k);
    return {2'(i), 16'(k)};
  endfunction

  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es,
                       input logic ev, input logic eb, input logic [17:0] eo);
    tests_run++;
    if (gnt !== eg || sel !== es || bus_valid !== ev || busy !== eb || bus_out !== eo) begin
      tests_failed++;
      $display("FAIL %s: got gnt=%b sel=%0d vld=%b busy=%b bus=%h, want gnt=%b sel=%0d vld=%b busy=%b bus=%h",
               name, gnt, sel, bus_valid, busy, bus_out, eg, es, ev, eb, eo);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_const_data();
    in0 = D0; in1 = D1; in2 = D2; in3 = D3;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    req   = 4'h0;
    set_const_data();

    // Expected outputs are those visible just after the edge that samples the row's inputs.
    vecs[0]  = mk(1'b0, 4'hF, 4'b0000, 2'd0, 1'b0, 1'b0, 18'h0);
    vecs[1]  = mk(1'b0, 4'hF, 4'b0000, 2'd0, 1'b0, 1'b0, 18'h0);
    vecs[2]  = mk(1'b1, 4'h1, 4'b0001, 2'd0, 1'b0, 1'b1, 18'h0);
    vecs[3]  = mk(1'b1, 4'h1, 4'b0001, 2'd0, 1'b1, 1'b1, D0);
    vecs[4]  = mk(1'b1, 4'h0, 4'b0000, 2'd0, 1'b0, 1'b1, D0);
    vecs[5]  = mk(1'b1, 4'h0, 4'b0000, 2'd0, 1'b0, 1'b0, D0);
    vecs[6]  = mk(1'b1, 4'h4, 4'b0100, 2'd2, 1'b0, 1'b1, D0);
    vecs[7]  = mk(1'b1, 4'h4, 4'b0100, 2'd2, 1'b1, 1'b1, D2);
    vecs[8]  = mk(1'b1, 4'h0, 4'b0000, 2'd2, 1'b0, 1'b1, D2);
    vecs[9]  = mk(1'b1, 4'h2, 4'b0010, 2'd1, 1'b0, 1'b1, D2);
    vecs[10] = mk(1'b1, 4'hA, 4'b0010, 2'd1, 1'b1, 1'b1, D1);
    vecs[11] = mk(1'b1, 4'hA, 4'b0010, 2'd1, 1'b1, 1'b1, D1);
    vecs[12] = mk(1'b1, 4'h8, 4'b0000, 2'd1, 1'b0, 1'b1, D1);
    vecs[13] = mk(1'b1, 4'h8, 4'b1000, 2'd3, 1'b0, 1'b1, D1);
    vecs[14] = mk(1'b1, 4'h8, 4'b1000, 2'd3, 1'b1, 1'b1, D3);
    vecs[15] = mk(1'b1, 4'h8, 4'b1000, 2'd3, 1'b1, 1'b1, D3);
    vecs[16] = mk(1'b1, 4'h8, 4'b1000, 2'd3, 1'b1, 1'b1, D3);
    vecs[17] = mk(1'b0, 4'h8, 4'b0000, 2'd0, 1'b0, 1'b0, 18'h0);
    vecs[18] = mk(1'b1, 4'h9, 4'b0001, 2'd0, 1'b0, 1'b1, 18'h0);
    vecs[19] = mk(1'b1, 4'h9, 4'b0001, 2'd0, 1'b1, 1'b1, D0);

    tick();
    for (int i = 0; i < 20; i++) begin
      rst_n = vecs[i].rst_n;
      req   = vecs[i].req;
      tick();
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].vld,
            vecs[i].busy, vecs[i].bout);
    end

    // Full contention: 8 grant cycles per owner, one idle-grant cycle, 36-cycle period.
    rst_n = 1'b0;
    req   = 4'hF;
    tick();
    tick();
    check("cont_reset", 4'b0000, 2'd0, 1'b0, 1'b0, 18'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 72; k++) begin
      int          slot;
      int          own;
      logic [3:0]  eg;
      logic [17:0] eo;
      in0 = fdat(0, k); in1 = fdat(1, k); in2 = fdat(2, k); in3 = fdat(3, k);
      tick();
      slot = k % 9;
      own  = (k / 9) % 4;
      eg   = (slot < 8) ? (4'b0001 << own) : 4'b0000;
      if (slot >= 1)   eo = fdat(own, k);
      else if (k == 0) eo = 18'h0;
      else             eo = fdat(((k - 1) / 9) % 4, k - 1);
      check($sformatf("cont_k%0d", k), eg, 2'(own), (slot >= 1), 1'b1, eo);
    end

    // Uncontended hold for 20 cycles, then a late competitor forces rotation.
    set_const_data();
    rst_n = 1'b0;
    req   = 4'h0;
    tick();
    rst_n = 1'b1;
    req   = 4'h1;
    for (int j = 0; j < 20; j++) begin
      tick();
      check($sformatf("hold_j%0d", j), 4'b0001, 2'd0, (j >= 1), 1'b1, (j >= 1) ? D0 : 18'h0);
    end
    req = 4'h5;
    tick();
    check("hold_rotate_sw", 4'b0000, 2'd0, 1'b1, 1'b1, D0);
    tick();
    check("hold_rotate_gnt", 4'b0100, 2'd2, 1'b0, 1'b1, D0);

    // Owner drops its request on the same edge its tenure times out.
    rst_n = 1'b0;
    req   = 4'h0;
    tick();
    rst_n = 1'b1;
    req   = 4'hF;
    for (int k = 0; k < 8; k++) tick();
    check("overlap_last_gnt", 4'b0001, 2'd0, 1'b1, 1'b1, D0);
    req = 4'hE;
    tick();
    check("overlap_switch", 4'b0000, 2'd0, 1'b0, 1'b1, D0);
    tick();
    check("overlap_next", 4'b0010, 2'd1, 1'b0, 1'b1, D0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
